acl_reg: RTL and testbench

//  Accumulator (AC) and Link (L) register for the PDP-8 datapath; the consumer end of the ALU result bus.
//  - Captures the adder/AND result bus (S, CO) on TAD/AND loads.
//  - Sequences OPR group-1 microinstructions over fixed micro-steps: clear -> complement -> increment -> rotate.
//  - Exports AC, L and skip flags for the CPU control FSM.

---
 rtl/acl_pkg.sv | 25 ++
 rtl/acl_rotator.sv | 41 ++++
 rtl/acl_reg.sv | 123 ++++++++++++
 tb/tb_acl_reg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acl_pkg.sv
// Shared types and constants for the PDP-8 AC/Link register block.
package acl_pkg;

    localparam int unsigned ACL_W = 12;

    // Bit positions within the group-1 OPR microinstruction field
    localparam int unsigned OPR_CLA   = 7;
    localparam int unsigned OPR_CLL   = 6;
    localparam int unsigned OPR_CMA   = 5;
    localparam int unsigned OPR_CML   = 4;
    localparam int unsigned OPR_RAR   = 3;
    localparam int unsigned OPR_RAL   = 2;
    localparam int unsigned OPR_TWICE = 1;
    localparam int unsigned OPR_IAC   = 0;

    typedef enum logic [2:0] {
        IDLE,
        S_CLR,
        S_CMP,
        S_INC,
        S_ROT1,
        S_ROT2
    } acl_state_e;

endpackage

// File: rtl/acl_rotator.sv
// Combinational one-place rotate of the 13-bit {L,AC} word.
// The AC byte-swap path exists only when ACL_BSW_EN is defined.
module acl_rotator
    import acl_pkg::*;
#(
    parameter int unsigned W = ACL_W
) (
    input  logic [W:0] la_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       bsw_i,
    output logic [W:0] la_o
);

`ifdef ACL_BSW_EN
    always_comb begin
        la_o = la_i;
        if (left_i && !right_i) begin
            la_o = {la_i[W-1:0], la_i[W]};
        end else if (right_i && !left_i) begin
            la_o = {la_i[0], la_i[W:1]};
        end else if (bsw_i) begin
            // Link stays put; only the two AC halves trade places
            la_o = {la_i[W], la_i[W/2-1:0], la_i[W-1:W/2]};
        end
    end
`else
    logic bsw_unused;
    assign bsw_unused = bsw_i;

    always_comb begin
        la_o = la_i;
        if (left_i && !right_i) begin
            la_o = {la_i[W-1:0], la_i[W]};
        end else if (right_i && !left_i) begin
            la_o = {la_i[0], la_i[W:1]};
        end
    end
`endif

endmodule

// File: rtl/acl_reg.sv
// PDP-8 accumulator and link register with a fixed-latency OPR group-1 sequencer.
// Optional byte swap (TWICE without a rotate direction) is enabled by ACL_BSW_EN.
module acl_reg
    import acl_pkg::*;
#(
    parameter int unsigned W = ACL_W
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] BUS_S,
    input  logic         BUS_CO,
    input  logic         LD_ADD,
    input  logic         LD_AND,
    input  logic         OPR_START,
    input  logic [7:0]   OPR_BITS,
    output logic [W-1:0] AC,
    output logic         LINK,
    output logic         BUSY,
    output logic         DONE,
    output logic         AC_ZERO,
    output logic         AC_NEG
);

    acl_state_e   state_q, state_d;
    logic [W-1:0] ac_q, ac_d;
    logic         link_q, link_d;
    logic [7:0]   opr_q, opr_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [W:0]   inc_sum;
    logic [W:0]   rot_out;
    logic         rot_bsw;

    assign inc_sum = {1'b0, ac_q} + {{W{1'b0}}, 1'b1};
    assign rot_bsw = (state_q == S_ROT1) && opr_q[OPR_TWICE] &&
                     !opr_q[OPR_RAR] && !opr_q[OPR_RAL];

    acl_rotator #(
        .W (W)
    ) u_rotator (
        .la_i    ({link_q, ac_q}),
        .left_i  (opr_q[OPR_RAL]),
        .right_i (opr_q[OPR_RAR]),
        .bsw_i   (rot_bsw),
        .la_o    (rot_out)
    );

    always_comb begin
        state_d = state_q;
        ac_d    = ac_q;
        link_d  = link_q;
        opr_d   = opr_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (LD_ADD) begin
                    ac_d   = BUS_S;
                    link_d = link_q ^ BUS_CO;
                end else if (LD_AND) begin
                    ac_d = BUS_S;
                end else if (OPR_START) begin
                    opr_d   = OPR_BITS;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                if (opr_q[OPR_CLA]) ac_d = '0;
                if (opr_q[OPR_CLL]) link_d = 1'b0;
                state_d = S_CMP;
            end
            S_CMP: begin
                if (opr_q[OPR_CMA]) ac_d = ~ac_q;
                if (opr_q[OPR_CML]) link_d = ~link_q;
                state_d = S_INC;
            end
            S_INC: begin
                if (opr_q[OPR_IAC]) begin
                    ac_d   = inc_sum[W-1:0];
                    link_d = link_q ^ inc_sum[W];
                end
                state_d = S_ROT1;
            end
            S_ROT1: begin
                {link_d, ac_d} = rot_out;
                state_d        = S_ROT2;
            end
            S_ROT2: begin
                if (opr_q[OPR_TWICE]) {link_d, ac_d} = rot_out;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ac_q    <= '0;
            link_q  <= 1'b0;
            opr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            link_q  <= link_d;
            opr_q   <= opr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign AC      = ac_q;
    assign LINK    = link_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign AC_ZERO = (ac_q == '0);
    assign AC_NEG  = ac_q[W-1];

endmodule

// File: tb/tb_acl_reg.sv
// Scoreboard bench for acl_reg: driver pushes expected {AC,L} with a due cycle, monitor checks.
module tb_acl_reg;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [11:0] BUS_S = '0;
    logic        BUS_CO = 1'b0;
    logic        LD_ADD = 1'b0;
    logic        LD_AND = 1'b0;
    logic        OPR_START = 1'b0;
    logic [7:0]  OPR_BITS = '0;
    logic [11:0] AC;
    logic        LINK, BUSY, DONE, AC_ZERO, AC_NEG;

    acl_reg dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BUS_S     (BUS_S),
        .BUS_CO    (BUS_CO),
        .LD_ADD    (LD_ADD),
        .LD_AND    (LD_AND),
        .OPR_START (OPR_START),
        .OPR_BITS  (OPR_BITS),
        .AC        (AC),
        .LINK      (LINK),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .AC_ZERO   (AC_ZERO),
        .AC_NEG    (AC_NEG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          due;
        bit          opr;
        logic [11:0] ac;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          m_ac = 0;
    int          m_l = 0;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual %0o required %0o (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain arithmetic on AC and L, applied in micro-step order
    function automatic int opr_ref(input int ac_in, input int l_in, input logic [7:0] b);
        int ac = ac_in;
        int l = l_in;
        int x;
        int n = 0;
        bit rl = b[2] && !b[3];
        bit rr = b[3] && !b[2];
        if (b[7]) ac = 0;
        if (b[6]) l = 0;
        if (b[5]) ac = 4095 - ac;
        if (b[4]) l = 1 - l;
        if (b[0]) begin
            ac = ac + 1;
            if (ac == 4096) begin
                ac = 0;
                l = 1 - l;
            end
        end
        x = l * 4096 + ac;
        if (rl || rr) n = b[1] ? 2 : 1;
        for (int i = 0; i < n; i++) begin
            if (rl) x = (x * 2) % 8192 + x / 4096;
            else    x = x / 2 + (x % 2) * 4096;
        end
`ifdef ACL_BSW_EN
        if (b[1] && !b[2] && !b[3]) begin
            ac = x % 4096;
            x = (x / 4096) * 4096 + (ac % 64) * 64 + ac / 64;
        end
`endif
        return x;
    endfunction

    always @(negedge CLK) begin
        if (RST_N) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk(e.opr ? "opr_done" : "load_nodone", DONE, e.opr);
                chk(e.opr ? "opr_ac" : "load_ac", AC, e.ac);
                chk(e.opr ? "opr_link" : "load_link", LINK, e.l);
                chk("ac_zero", AC_ZERO, e.ac == 12'o0);
                chk("ac_neg", AC_NEG, e.ac[11]);
            end else if (DONE) begin
                chk("unexpected_done", DONE, 1'b0);
            end
        end
    end

    task automatic do_load(input bit is_add, input logic [11:0] s, input logic co);
        exp_t e;
        @(posedge CLK); #1;
        LD_ADD = is_add;
        LD_AND = !is_add;
        BUS_S  = s;
        BUS_CO = co;
        m_ac = int'(s);
        if (is_add) m_l = m_l ^ int'(co);
        e.due = cyc + 1; e.opr = 1'b0; e.ac = 12'(m_ac); e.l = m_l[0];
        sb.push_back(e);
        @(posedge CLK); #1;
        LD_ADD = 1'b0;
        LD_AND = 1'b0;
        BUS_CO = $urandom_range(0, 1);
        BUS_S  = 12'($urandom_range(0, 4095));
    endtask

    task automatic do_opr(input logic [7:0] bits, output int busy_cnt);
        exp_t e;
        int   r;
        busy_cnt = 0;
        @(posedge CLK); #1;
        OPR_START = 1'b1;
        OPR_BITS  = bits;
        r = opr_ref(m_ac, m_l, bits);
        m_ac = r % 4096;
        m_l  = r / 4096;
        e.due = cyc + 6; e.opr = 1'b1; e.ac = 12'(m_ac); e.l = m_l[0];
        sb.push_back(e);
        @(posedge CLK); #1;
        OPR_START = 1'b0;
        OPR_BITS  = 8'($urandom_range(0, 255));
        repeat (6) begin
            @(negedge CLK);
            if (BUSY) busy_cnt++;
        end
    endtask

    task automatic set_state(input logic [11:0] ac, input bit l);
        int bc;
        do_opr(l ? 8'hD0 : 8'hC0, bc);
        do_load(1'b0, ac, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual %0d required 0 (cycle budget exhausted)", cyc);
        $fatal(1);
    end

    initial begin
        int bc;
        exp_t e;
        #2;
        chk("reset_ac", AC, 12'o0);
        chk("reset_link", LINK, 1'b0);
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_done", DONE, 1'b0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // Loads
        do_load(1'b1, 12'o7777, 1'b1);
        do_load(1'b0, 12'o0123, 1'b0);

        // CLA CLL CMA IAC: five busy cycles then DONE
        set_state(12'o1234, 1'b0);
        do_opr(8'hE1, bc);
        chk("busy_cycles", bc, 5);

        set_state(12'o4001, 1'b0);
        do_opr(8'h06, bc);
        set_state(12'o0001, 1'b0);
        do_opr(8'h08, bc);

        set_state(12'o1234, 1'b1);
        do_opr(8'h02, bc);
        set_state(12'o1234, 1'b0);
        do_opr(8'h02, bc);

        // Requests while busy must be ignored
        set_state(12'o0777, 1'b0);
        @(posedge CLK); #1;
        OPR_START = 1'b1;
        OPR_BITS  = 8'h21;
        m_ac = opr_ref(m_ac, m_l, 8'h21) % 4096;
        e.due = cyc + 6; e.opr = 1'b1; e.ac = 12'(m_ac); e.l = m_l[0];
        sb.push_back(e);
        @(posedge CLK); #1;
        OPR_START = 1'b0;
        @(posedge CLK); #1;
        LD_ADD = 1'b1; BUS_S = 12'o7777; BUS_CO = 1'b1;
        OPR_START = 1'b1; OPR_BITS = 8'h80;
        @(posedge CLK); #1;
        LD_ADD = 1'b0; OPR_START = 1'b0;
        repeat (8) @(posedge CLK);

        // Load beats OPR_START in the same idle cycle
        #1;
        LD_ADD = 1'b1; BUS_S = 12'o2525; BUS_CO = 1'b1;
        OPR_START = 1'b1; OPR_BITS = 8'h80;
        m_ac = 12'o2525; m_l = m_l ^ 1;
        e.due = cyc + 1; e.opr = 1'b0; e.ac = 12'(m_ac); e.l = m_l[0];
        sb.push_back(e);
        @(posedge CLK); #1;
        LD_ADD = 1'b0; OPR_START = 1'b0;
        @(negedge CLK);
        chk("collision_nobusy", BUSY, 1'b0);
        repeat (8) @(posedge CLK);

        // Reset mid-sequence aborts with no DONE
        #1;
        OPR_START = 1'b1; OPR_BITS = 8'hFF;
        @(posedge CLK); #1;
        OPR_START = 1'b0;
        @(posedge CLK); #1;
        chk("abort_busy_before", BUSY, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("abort_ac", AC, 12'o0);
        chk("abort_link", LINK, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        m_ac = 0; m_l = 0;
        repeat (10) @(posedge CLK);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: do_load(1'b1, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
                1: do_load(1'b0, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
                default: begin
                    do_opr(8'($urandom_range(0, 255)), bc);
                    chk("rand_busy_cycles", bc, 5);
                end
            endcase
        end

        repeat (10) @(posedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
